// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache.
// Serves core fetch requests from a valid/tag/data array and refills a whole
// line from instruction memory (one word per beat) on a miss. A flush pulse
// invalidates every line on the next IDLE cycle.
module icache #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icache_req,
    input  logic [31:0] icache_addr,
    input  logic        icache_flush,
    output logic        icache_valid,
    output logic [31:0] icache_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int OB    = 2 + OFF_W;
    localparam int TAG_W = 32 - OB - IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_r;
    logic [LINES-1:0]   valid_r;
    logic               flush_pending_r;
    logic [OFF_W-1:0]   beat_r;
    logic [OFF_W-1:0]   fill_off_r;
    logic [IDX_W-1:0]   fill_idx_r;
    logic [TAG_W-1:0]   fill_tag_r;

    logic [TAG_W-1:0]   tag_mem_r  [LINES];
    logic [31:0]        data_mem_r [LINES*WORDS_PER_LINE];

    logic [OFF_W-1:0]   req_off_s;
    logic [IDX_W-1:0]   req_idx_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic               hit_s;
    logic [31:0]        hit_word_s;
    logic               refill_wr_s;
    logic               last_beat_s;
    logic               flush_now_s;
    logic               unused_addr_s;

    // Byte-offset bits never select anything; kept only to document that.
    assign unused_addr_s = ^icache_addr[1:0];

    // Address decode, hit detection and refill write strobes.
    always_comb begin
        req_off_s   = icache_addr[OB-1:2];
        req_idx_s   = icache_addr[OB+IDX_W-1:OB];
        req_tag_s   = icache_addr[31:OB+IDX_W];
        hit_s       = 1'b0;
        hit_word_s  = data_mem_r[{req_idx_s, req_off_s}];
        if (valid_r[req_idx_s] && (tag_mem_r[req_idx_s] == req_tag_s)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        refill_wr_s = (state_r == REFILL) && mem_rvalid;
        last_beat_s = (beat_r == OFF_W'(WORDS_PER_LINE - 1));
        // A pulse arriving in IDLE is honoured immediately, same as a pending one.
        flush_now_s = flush_pending_r || icache_flush;
    end

    // Tag and data arrays: no reset, written only by refill beats.
    always_ff @(posedge clk) begin
        if (refill_wr_s) begin
            data_mem_r[{fill_idx_r, beat_r}] <= mem_rdata;
            if (last_beat_s) begin
                tag_mem_r[fill_idx_r] <= fill_tag_r;
            end
        end
    end

    // Control FSM with registered core and memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            valid_r         <= {LINES{1'b0}};
            flush_pending_r <= 1'b0;
            beat_r          <= {OFF_W{1'b0}};
            fill_off_r      <= {OFF_W{1'b0}};
            fill_idx_r      <= {IDX_W{1'b0}};
            fill_tag_r      <= {TAG_W{1'b0}};
            icache_valid    <= 1'b0;
            icache_data     <= 32'd0;
            mem_req         <= 1'b0;
            mem_addr        <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    icache_valid <= 1'b0;
                    if (flush_now_s) begin
                        // Request (if any) is re-evaluated next cycle and misses.
                        valid_r         <= {LINES{1'b0}};
                        flush_pending_r <= 1'b0;
                    end else if (icache_req) begin
                        if (hit_s) begin
                            icache_data  <= hit_word_s;
                            icache_valid <= 1'b1;
                            state_r      <= RESP;
                        end else begin
                            valid_r[req_idx_s] <= 1'b0;
                            beat_r             <= {OFF_W{1'b0}};
                            fill_off_r         <= req_off_s;
                            fill_idx_r         <= req_idx_s;
                            fill_tag_r         <= req_tag_s;
                            mem_addr           <= {icache_addr[31:OB], {OB{1'b0}}};
                            mem_req            <= 1'b1;
                            state_r            <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    flush_pending_r <= flush_pending_r | icache_flush;
                    if (mem_rvalid) begin
                        if (beat_r == fill_off_r) begin
                            icache_data <= mem_rdata;
                        end
                        beat_r   <= beat_r + OFF_W'(1);
                        mem_addr <= mem_addr + 32'd4;
                        if (last_beat_s) begin
                            valid_r[fill_idx_r] <= 1'b1;
                            mem_req             <= 1'b0;
                            icache_valid        <= 1'b1;
                            state_r             <= RESP;
                        end
                    end
                end
                RESP: begin
                    flush_pending_r <= flush_pending_r | icache_flush;
                    icache_valid    <= 1'b0;
                    state_r         <= IDLE;
                end
                default: begin
                    state_r      <= IDLE;
                    icache_valid <= 1'b0;
                    mem_req      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed testbench for icache (LINES=16, WORDS_PER_LINE=4).
// Memory model returns 0xA000_0000 | address, with an optional fixed gap
// of idle cycles before each beat.
module tb_icache;

    logic        clk;
    logic        rst_n;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_flush;
    logic        icache_valid;
    logic [31:0] icache_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int          n_cmp;
    int          n_bad;
    int          stall_cfg;
    int          gap_r;
    int          vcnt;
    int          mreq_cnt;
    int          hold_err;
    logic [31:0] beats[$];
    logic        prev_req;
    logic        prev_rvalid;
    logic [31:0] prev_addr;

    icache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .icache_req   (icache_req),
        .icache_addr  (icache_addr),
        .icache_flush (icache_flush),
        .icache_valid (icache_valid),
        .icache_data  (icache_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory data and beat acceptance.
    always_comb begin
        mem_rdata  = 32'hA000_0000 | mem_addr;
        mem_rvalid = mem_req && (gap_r == 0);
    end

    // Idle-cycle counter inserted before every beat.
    always @(posedge clk) begin
        if (!mem_req) gap_r <= stall_cfg;
        else if (mem_rvalid) gap_r <= stall_cfg;
        else if (gap_r > 0) gap_r <= gap_r - 1;
    end

    // Output monitor sampled mid-cycle.
    initial begin
        vcnt = 0; mreq_cnt = 0; hold_err = 0;
        prev_req = 1'b0; prev_rvalid = 1'b0; prev_addr = 32'd0;
        forever begin
            @(negedge clk);
            if (icache_valid) vcnt++;
            if (mem_req) mreq_cnt++;
            if (mem_req && mem_rvalid) beats.push_back(mem_addr);
            if (mem_req && prev_req && !prev_rvalid && (mem_addr != prev_addr)) hold_err++;
            prev_req = mem_req; prev_rvalid = mem_rvalid; prev_addr = mem_addr;
        end
    end

    // Single comparison point.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one fetch (optionally with a flush pulse in the first cycle);
    // returns the number of edges until icache_valid and the data seen.
    task automatic do_req(input logic [31:0] a, input logic fl,
                          output int cyc, output logic [31:0] dat, output logic first_mreq);
        icache_addr = a; icache_req = 1'b1; icache_flush = fl;
        cyc = 0; dat = 32'd0; first_mreq = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            icache_flush = 1'b0;
            cyc++;
            if (i == 0) first_mreq = mem_req;
            if (icache_valid) begin
                dat = icache_data;
                break;
            end
        end
        icache_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // Check the four refill beat addresses recorded from position b0.
    task automatic chk_line(input string tag, input logic [31:0] base, input int b0);
        chk({tag, "_nbeats"}, 32'(beats.size() - b0), 32'd4);
        if (beats.size() >= b0 + 4) begin
            for (int k = 0; k < 4; k++) chk({tag, "_addr"}, beats[b0 + k], base + 32'(4 * k));
        end
    endtask

    int          cyc;
    logic [31:0] dat;
    logic        fm;
    int          b0;
    int          v0;
    int          m0;

    initial begin
        n_cmp = 0; n_bad = 0; stall_cfg = 0;
        rst_n = 1'b0; icache_req = 1'b0; icache_addr = 32'd0; icache_flush = 1'b0;
        #3;
        chk("rst_valid", {31'd0, icache_valid}, 32'd0);
        chk("rst_data", icache_data, 32'd0);
        chk("rst_mreq", {31'd0, mem_req}, 32'd0);
        chk("rst_maddr", mem_addr, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold miss, zero-wait memory.
        b0 = beats.size(); v0 = vcnt;
        do_req(32'h0000_0104, 1'b0, cyc, dat, fm);
        chk("cold_lat", 32'(cyc), 32'd5);
        chk("cold_data", dat, 32'hA000_0104);
        chk("cold_vcnt", 32'(vcnt - v0), 32'd1);
        chk_line("cold", 32'h0000_0100, b0);

        // Hit in the refilled line.
        m0 = mreq_cnt;
        do_req(32'h0000_010C, 1'b0, cyc, dat, fm);
        chk("hit_lat", 32'(cyc), 32'd1);
        chk("hit_data", dat, 32'hA000_010C);
        chk("hit_mreq", 32'(mreq_cnt - m0), 32'd0);

        // Conflict on index 0, then the evicted line misses again.
        b0 = beats.size();
        do_req(32'h0000_0204, 1'b0, cyc, dat, fm);
        chk("conf_data", dat, 32'hA000_0204);
        chk_line("conf", 32'h0000_0200, b0);
        b0 = beats.size();
        do_req(32'h0000_0104, 1'b0, cyc, dat, fm);
        chk("evict_lat", 32'(cyc), 32'd5);
        chk("evict_data", dat, 32'hA000_0104);
        chk_line("evict", 32'h0000_0100, b0);

        // Flush with a simultaneous request to a valid line.
        b0 = beats.size(); v0 = vcnt;
        do_req(32'h0000_0104, 1'b1, cyc, dat, fm);
        chk("flush_first_mreq", {31'd0, fm}, 32'd0);
        chk("flush_lat", 32'(cyc), 32'd6);
        chk("flush_data", dat, 32'hA000_0104);
        chk("flush_vcnt", 32'(vcnt - v0), 32'd1);
        chk("flush_nbeats", 32'(beats.size() - b0), 32'd4);

        // Stalled memory on a miss at 0x108 (flush first so it misses).
        icache_flush = 1'b1;
        @(posedge clk); #1; icache_flush = 1'b0;
        @(posedge clk); #1;
        stall_cfg = 3;
        b0 = beats.size(); v0 = vcnt;
        do_req(32'h0000_0108, 1'b0, cyc, dat, fm);
        stall_cfg = 0;
        chk("stall_lat", 32'(cyc), 32'd17);
        chk("stall_data", dat, 32'hA000_0108);
        chk("stall_vcnt", 32'(vcnt - v0), 32'd1);
        chk("stall_hold", 32'(hold_err), 32'd0);
        chk_line("stall", 32'h0000_0100, b0);

        // Reset during the second refill beat.
        icache_addr = 32'h0000_0304; icache_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_maddr", mem_addr, 32'h0000_0304);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, icache_valid}, 32'd0);
        chk("arst_data", icache_data, 32'd0);
        chk("arst_mreq", {31'd0, mem_req}, 32'd0);
        chk("arst_maddr", mem_addr, 32'd0);
        icache_req = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        b0 = beats.size();
        do_req(32'h0000_0104, 1'b0, cyc, dat, fm);
        chk("post_lat", 32'(cyc), 32'd5);
        chk("post_data", dat, 32'hA000_0104);
        chk_line("post", 32'h0000_0100, b0);
        b0 = beats.size();
        do_req(32'h0000_0304, 1'b0, cyc, dat, fm);
        chk("aborted_lat", 32'(cyc), 32'd5);
        chk("aborted_data", dat, 32'hA000_0304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
